// File: rtl/return_address_stack_pkg.sv
// Return-address stack shared types and constants.
// Link-register encodings used by decode to classify calls/returns.
package return_address_stack_pkg;

  localparam int RAS_DEPTH  = 8;
  localparam int RAS_ADDR_W = 32;
  localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  function automatic logic is_link(
    input logic [4:0] r
  );
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/commit-side bundle between the pipeline and the
// return-address stack.
interface return_address_stack_if
  import return_address_stack_pkg::*;
#(
  parameter int ADDR_W = RAS_ADDR_W
) ();

  logic              Push_En;
  logic [ADDR_W-1:0] Push_Addr;
  logic              Pop_En;
  logic [ADDR_W-1:0] Top_Addr;
  logic              Top_Valid;
  logic              Pop_Underflow;
  logic              Commit_Push;
  logic              Commit_Pop;
  logic [ADDR_W-1:0] Commit_Addr;
  logic              Flush;

  modport master (
    output Push_En, Push_Addr, Pop_En,
    output Commit_Push, Commit_Pop,
    output Commit_Addr, Flush,
    input  Top_Addr, Top_Valid,
    input  Pop_Underflow
  );

  modport slave (
    input  Push_En, Push_Addr, Pop_En,
    input  Commit_Push, Commit_Pop,
    input  Commit_Addr, Flush,
    output Top_Addr, Top_Valid,
    output Pop_Underflow
  );

endinterface

// File: rtl/ras_stack_core.sv
// One circular return-address stack with saturating count.
// Exposes next-state so a sibling stack can be restored from it.
module ras_stack_core
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = RAS_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic                          load_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  load_ent_i,
  input  logic [PTR_W-1:0]              load_sp_i,
  input  logic [CNT_W-1:0]              load_cnt_i,
  output logic [ADDR_W-1:0]             top_o,
  output logic [CNT_W-1:0]              cnt_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  nxt_ent_o,
  output logic [PTR_W-1:0]              nxt_sp_o,
  output logic [CNT_W-1:0]              nxt_cnt_o
);

  logic [DEPTH-1:0][ADDR_W-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]             sp_q, sp_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [ADDR_W-1:0] a;
  logic [PTR_W-1:0]  sp_inc, sp_dec;
  logic              has, full;
  logic              do_repl, do_push, do_pop;

  assign a      = {addr_i[ADDR_W-1:1], 1'b0};
  assign sp_inc = sp_q + PTR_W'(1);
  assign sp_dec = sp_q - PTR_W'(1);
  assign has    = cnt_q != '0;
  assign full   = cnt_q == CNT_W'(DEPTH);

  // Push+pop on a non-empty stack replaces the top (coroutine swap).
  assign do_repl = ~load_i & push_i & pop_i & has;
  assign do_push = ~load_i & push_i & ~(pop_i & has);
  assign do_pop  = ~load_i & ~push_i & pop_i & has;

  always_comb begin
    ent_d = ent_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      load_i: begin
        ent_d = load_ent_i;
        sp_d  = load_sp_i;
        cnt_d = load_cnt_i;
      end
      do_repl: ent_d[sp_q] = a;
      do_push: begin
        sp_d          = sp_inc;
        ent_d[sp_inc] = a;
        if (!full) cnt_d = cnt_q + CNT_W'(1);
      end
      do_pop: begin
        sp_d  = sp_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign top_o     = ent_q[sp_q];
  assign cnt_o     = cnt_q;
  assign nxt_ent_o = ent_d;
  assign nxt_sp_o  = sp_d;
  assign nxt_cnt_o = cnt_d;

endmodule

// File: rtl/return_address_stack.sv
// Speculative + committed return-address stacks; flush restores
// the speculative copy from the committed stack's next state.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int ADDR_W = RAS_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input logic clk,
  input logic rst,
  return_address_stack_if.slave bus
);

  logic [DEPTH-1:0][ADDR_W-1:0] c_ent, s_ent;
  logic [PTR_W-1:0]             c_sp, s_sp;
  logic [CNT_W-1:0]             c_cnt, s_nc;
  logic [ADDR_W-1:0]            s_top, c_top;
  logic [CNT_W-1:0]             s_cnt, c_cc;

  ras_stack_core #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_commit (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.Commit_Push),
    .pop_i     (bus.Commit_Pop),
    .addr_i    (bus.Commit_Addr),
    .load_i    (1'b0),
    .load_ent_i('0),
    .load_sp_i ('0),
    .load_cnt_i('0),
    .top_o     (c_top),
    .cnt_o     (c_cc),
    .nxt_ent_o (c_ent),
    .nxt_sp_o  (c_sp),
    .nxt_cnt_o (c_cnt)
  );

  ras_stack_core #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_spec (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.Push_En),
    .pop_i     (bus.Pop_En),
    .addr_i    (bus.Push_Addr),
    .load_i    (bus.Flush),
    .load_ent_i(c_ent),
    .load_sp_i (c_sp),
    .load_cnt_i(c_cnt),
    .top_o     (s_top),
    .cnt_o     (s_cnt),
    .nxt_ent_o (s_ent),
    .nxt_sp_o  (s_sp),
    .nxt_cnt_o (s_nc)
  );

  logic unused_state;
  assign unused_state = ^{c_top, c_cc, s_ent, s_sp, s_nc};

  assign bus.Top_Addr      = s_top;
  assign bus.Top_Valid     = s_cnt != '0;
  assign bus.Pop_Underflow = bus.Pop_En & ~bus.Push_En
                           & ~bus.Flush & (s_cnt == '0);

endmodule

// File: tb/tb_return_address_stack.sv
// Return-address stack bench: directed scenarios plus random
// traffic against queue-based speculative/committed models.
module tb_return_address_stack;

  typedef logic [31:0] q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  return_address_stack_if bus ();

  return_address_stack #(
    .DEPTH (8),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  q_t sq;
  q_t cq;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic q_t apply(
    input q_t          q,
    input bit          push,
    input bit          pop,
    input logic [31:0] addr
  );
    logic [31:0] a;
    a = addr & ~32'h1;
    if (push && pop && q.size() > 0) begin
      q[q.size()-1] = a;
    end else if (push) begin
      q.push_back(a);
      if (q.size() > 8) void'(q.pop_front());
    end else if (pop && q.size() > 0) begin
      void'(q.pop_back());
    end
    return q;
  endfunction

  task automatic cyc(
    input bit          push,
    input logic [31:0] pa,
    input bit          pop,
    input bit          cpush,
    input bit          cpop,
    input logic [31:0] ca,
    input bit          fl
  );
    bus.Push_En     = push;
    bus.Push_Addr   = pa;
    bus.Pop_En      = pop;
    bus.Commit_Push = cpush;
    bus.Commit_Pop  = cpop;
    bus.Commit_Addr = ca;
    bus.Flush       = fl;
    #3;
    chk("uflow", 32'(bus.Pop_Underflow),
        32'(pop && !push && !fl && sq.size() == 0));
    chk("valid", 32'(bus.Top_Valid), 32'(sq.size() != 0));
    if (sq.size() != 0) chk("top", bus.Top_Addr, sq[$]);
    @(posedge clk);
    cq = apply(cq, cpush, cpop, ca);
    if (fl) sq = cq;
    else    sq = apply(sq, push, pop, pa);
    #1;
  endtask

  task automatic spush(input logic [31:0] a);
    cyc(1, a, 0, 0, 0, 0, 0);
  endtask

  task automatic spop();
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bus.Push_En     = 0;
    bus.Push_Addr   = 0;
    bus.Pop_En      = 0;
    bus.Commit_Push = 0;
    bus.Commit_Pop  = 0;
    bus.Commit_Addr = 0;
    bus.Flush       = 0;
    #2;
    chk("rst_valid", 32'(bus.Top_Valid), 0);
    chk("rst_top", bus.Top_Addr, 0);
    chk("rst_uflow", 32'(bus.Pop_Underflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    spush(32'h1004);
    spush(32'h2008);
    spush(32'h300C);
    chk("t300c", bus.Top_Addr, 32'h300C);
    spop();
    chk("t2008", bus.Top_Addr, 32'h2008);
    spop();
    chk("t1004", bus.Top_Addr, 32'h1004);
    spop();
    chk("empty3", 32'(bus.Top_Valid), 0);

    spush(32'h4001);
    chk("align", bus.Top_Addr, 32'h4000);
    spop();

    for (int i = 0; i < 9; i++) spush(32'h100 + 32'(4 * i));
    chk("sat_top", bus.Top_Addr, 32'h120);
    for (int i = 0; i < 8; i++) begin
      chk("sat_pop", bus.Top_Addr, 32'h120 - 32'(4 * i));
      spop();
    end
    chk("sat_empty", 32'(bus.Top_Valid), 0);

    bus.Pop_En = 1;
    #1;
    chk("uflow_1", 32'(bus.Pop_Underflow), 1);
    spop();
    chk("uflow_v", 32'(bus.Top_Valid), 0);
    cyc(1, 32'h500, 1, 0, 0, 0, 0);
    chk("pp_top", bus.Top_Addr, 32'h500);
    spop();
    chk("pp_cnt1", 32'(bus.Top_Valid), 0);

    cyc(1, 32'hA00, 0, 1, 0, 32'hA00, 0);
    spush(32'hB00);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("fl_top", bus.Top_Addr, 32'hA00);
    spop();
    chk("fl_cnt1", 32'(bus.Top_Valid), 0);
    cyc(1, 32'hD00, 1, 1, 0, 32'hC00, 1);
    chk("fl_cmt", bus.Top_Addr, 32'hC00);

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 45, $urandom,
          $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 25, $urandom,
          $urandom_range(0, 99) < 5);
    end

    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h7000 + 32'(8 * i), 0, 1, 0,
          32'h7000 + 32'(8 * i), 0);
    chk("pre_rst", 32'(bus.Top_Valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.Top_Valid), 0);
    chk("arst_top", bus.Top_Addr, 0);
    sq.delete();
    cq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("arst_cmt", 32'(bus.Top_Valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
